seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with double-buffered digit memory,
// digit-boundary commit and per-digit blink attribute.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE_W = 17,
  parameter int BLINK_W    = 6,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [5:0]            wr_data,
  input  logic                  wr_blink,
  input  logic                  commit,
  output logic                  commit_ack,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n
);

  localparam logic [AW:0]   DIGIT_CNT  = (AW+1)'(NUM_DIGITS);
  localparam logic [AW-1:0] LAST_DIGIT = AW'(NUM_DIGITS - 1);

  logic [PRESCALE_W-1:0]       presc_q, presc_d;
  logic [AW-1:0]               digit_q, digit_d;
  logic [BLINK_W-1:0]          blink_q, blink_d;
  logic                        pending_q, pending_d;
  logic                        ack_q, ack_d;
  logic [NUM_DIGITS-1:0][6:0]  shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][6:0]  active_q, active_d;
  logic [NUM_DIGITS-1:0]       an_n_q, an_n_d;
  logic [6:0]                  seg_n_q, seg_n_d;
  logic                        dp_n_q, dp_n_d;
  logic                        wrap;
  logic                        blank;
  logic [6:0]                  entry;

  always_comb begin
    wrap    = (presc_q == '1);
    presc_d = presc_q + 1'b1;
    digit_d = digit_q;
    blink_d = blink_q;
    if (wrap) begin
      if (digit_q == LAST_DIGIT) begin
        digit_d = '0;
        blink_d = blink_q + 1'b1;
      end else begin
        digit_d = digit_q + 1'b1;
      end
    end
  end

  // A commit seen while one is pending (even in the wrap cycle itself) merges
  // into it; the copy uses the post-write shadow so same-cycle writes land.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && ({1'b0, wr_addr} < DIGIT_CNT)) begin
      shadow_d[wr_addr] = {wr_blink, wr_data};
    end
    ack_d     = wrap & pending_q;
    pending_d = wrap ? (commit & ~pending_q) : (pending_q | commit);
    active_d  = ack_d ? shadow_d : active_q;
  end

  always_comb begin
    entry   = active_q[digit_q];
    blank   = ~entry[5] | (entry[6] & blink_q[BLINK_W-1]);
    an_n_d  = '1;
    seg_n_d = 7'h7F;
    dp_n_d  = 1'b1;
    if (!blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_q == AW'(i)) an_n_d[i] = 1'b0;
      end
      dp_n_d = ~entry[0];
      case (entry[4:1])
        4'h0: seg_n_d = 7'b0000001;
        4'h1: seg_n_d = 7'b1001111;
        4'h2: seg_n_d = 7'b0010010;
        4'h3: seg_n_d = 7'b0000110;
        4'h4: seg_n_d = 7'b1001100;
        4'h5: seg_n_d = 7'b0100100;
        4'h6: seg_n_d = 7'b0100000;
        4'h7: seg_n_d = 7'b0001111;
        4'h8: seg_n_d = 7'b0000000;
        4'h9: seg_n_d = 7'b0000100;
        4'hA: seg_n_d = 7'b0001000;
        4'hB: seg_n_d = 7'b1100000;
        4'hC: seg_n_d = 7'b0110001;
        4'hD: seg_n_d = 7'b1000010;
        4'hE: seg_n_d = 7'b0110000;
        4'hF: seg_n_d = 7'b0111000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      digit_q   <= '0;
      blink_q   <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      an_n_q    <= '1;
      seg_n_q   <= 7'h7F;
      dp_n_q    <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      blink_q   <= blink_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
    end
  end

  assign commit_ack = ack_q;
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: an 8-digit and a 5-digit instance checked every
// cycle against a time-based display model, plus hand-computed spot checks.
module tb_seg_scan_ctrl;

  localparam int PW = 2;
  localparam int BW = 1;
  localparam int DIGIT_CYC = 1 << PW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic       wr_en    [2];
  logic [2:0] wr_addr  [2];
  logic [5:0] wr_data  [2];
  logic       wr_blink [2];
  logic       commit   [2];

  logic [7:0] an8;
  logic [6:0] seg8;
  logic       dp8, ack8;
  logic [4:0] an5;
  logic [6:0] seg5;
  logic       dp5, ack5;

  int vectors     = 0;
  int miscompares = 0;
  int t           = 0;
  int ack_cnt [2] = '{0, 0};
  int n_dig   [2] = '{8, 5};

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  logic [6:0]  m_shadow  [2][16];
  logic [6:0]  m_active  [2][16];
  bit          m_pending [2];
  logic [15:0] e_an  [2] = '{16'hFFFF, 16'hFFFF};
  logic [6:0]  e_seg [2] = '{7'h7F, 7'h7F};
  logic        e_dp  [2] = '{1'b1, 1'b1};
  logic        e_ack [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(8), .PRESCALE_W(PW), .BLINK_W(BW)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .wr_blink(wr_blink[0]), .commit(commit[0]),
    .commit_ack(ack8), .an_n(an8), .seg_n(seg8), .dp_n(dp8)
  );

  seg_scan_ctrl #(.NUM_DIGITS(5), .PRESCALE_W(PW), .BLINK_W(BW)) dut5 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .wr_blink(wr_blink[1]), .commit(commit[1]),
    .commit_ack(ack5), .an_n(an5), .seg_n(seg5), .dp_n(dp5)
  );

  // Model: t counts clocks since reset release; digit = (t/4) mod N,
  // blink phase flips every full scan; outputs lag that by one cycle.
  initial begin : model
    int d;
    bit ph, wrap_cyc;
    logic [6:0] ent;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        t = 0;
        for (int k = 0; k < 2; k++) begin
          m_pending[k] = 1'b0;
          e_an[k] = 16'hFFFF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1; e_ack[k] = 1'b0;
          for (int i = 0; i < 16; i++) begin
            m_shadow[k][i] = '0;
            m_active[k][i] = '0;
          end
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          d        = (t / DIGIT_CYC) % n_dig[k];
          ph       = (((t / (DIGIT_CYC * n_dig[k])) >> (BW - 1)) % 2) == 1;
          wrap_cyc = (t % DIGIT_CYC) == DIGIT_CYC - 1;
          ent      = m_active[k][d];
          if (!ent[5] || (ent[6] && ph)) begin
            e_an[k] = 16'hFFFF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
          end else begin
            e_an[k]  = ~(16'h0001 << d);
            e_seg[k] = seg_tab[ent[4:1]];
            e_dp[k]  = ~ent[0];
          end
          e_ack[k] = m_pending[k] && wrap_cyc;
          if (wr_en[k] && (int'(wr_addr[k]) < n_dig[k]))
            m_shadow[k][wr_addr[k]] = {wr_blink[k], wr_data[k]};
          if (e_ack[k])
            for (int i = 0; i < 16; i++) m_active[k][i] = m_shadow[k][i];
          m_pending[k] = wrap_cyc ? (commit[k] && !m_pending[k]) : (m_pending[k] || commit[k]);
        end
        t++;
      end
    end
  end

  initial begin : compare
    logic [15:0] a_an;
    logic [6:0]  a_seg;
    logic        a_dp, a_ack;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin
          a_an = {8'hFF, an8}; a_seg = seg8; a_dp = dp8; a_ack = ack8;
        end else begin
          a_an = {11'h7FF, an5}; a_seg = seg5; a_dp = dp5; a_ack = ack5;
        end
        if (a_ack) ack_cnt[k]++;
        vectors++;
        if ({a_an, a_seg, a_dp, a_ack} !== {e_an[k], e_seg[k], e_dp[k], e_ack[k]}) begin
          miscompares++;
          $display("[TB] FAIL model_dut%0d t=%0d: got an=%h seg=%b dp=%b ack=%b, expected an=%h seg=%b dp=%b ack=%b",
                   k, t, a_an, a_seg, a_dp, a_ack, e_an[k], e_seg[k], e_dp[k], e_ack[k]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input bit en, input logic [2:0] addr,
                               input logic [5:0] data, input bit bl, input bit cm);
    wr_en[k] = en; wr_addr[k] = addr; wr_data[k] = data; wr_blink[k] = bl; commit[k] = cm;
    @(negedge clk);
    wr_en[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0; wr_blink[k] = 1'b0; commit[k] = 1'b0;
  endtask

  task automatic waitPhase(input int m, input int v);
    int i = 0;
    while ((t % m) != v && i < 300) begin
      @(negedge clk);
      i++;
    end
    if ((t % m) != v) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL phase_timeout: got t=%0d, expected t mod %0d == %0d", t, m, v);
    end
  endtask

  task automatic waitAck(input int k, input int maxc);
    int i = 0;
    bit seen = 1'b0;
    while (!seen && i < maxc) begin
      @(negedge clk);
      i++;
      seen = (k == 0) ? ack8 : ack5;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL ack_timeout_dut%0d: got no ack in %0d cycles, expected one", k, maxc);
    end
  endtask

  initial begin : stimulus
    int base;
    for (int k = 0; k < 2; k++) begin
      wr_en[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0; wr_blink[k] = 1'b0; commit[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_an8", 32'(an8), 32'hFF);
    checkOutput("reset_seg8", 32'(seg8), 32'h7F);
    checkOutput("reset_dp8", 32'(dp8), 32'h1);
    checkOutput("reset_an5", 32'(an5), 32'h1F);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("idle_an8", 32'(an8), 32'hFF);
    checkOutput("idle_ack8", 32'(ack8), 32'h0);

    // Single digit: write + commit in the same cycle, just before the 7->0 wrap
    waitPhase(32, 28);
    applyStimulus(0, 1'b1, 3'd0, 6'b101011, 1'b0, 1'b1);
    waitPhase(32, 0);
    checkOutput("first_commit_ack", 32'(ack8), 32'h1);
    @(negedge clk);
    checkOutput("first_an8", 32'(an8), 32'hFE);
    checkOutput("first_seg8", 32'(seg8), 32'b0100100);
    checkOutput("first_dp8", 32'(dp8), 32'h0);
    checkOutput("ack_one_cycle", 32'(ack8), 32'h0);

    // All eight digits, scan order over two rounds
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1'b1, 3'(i), {1'b1, 4'(i + 8), 1'(i)}, 1'b0, 1'b0);
    waitPhase(32, 28);
    applyStimulus(0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1);
    waitPhase(32, 0);
    checkOutput("scan_commit_ack", 32'(ack8), 32'h1);
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      checkOutput($sformatf("scan_an8_%0d", j), 32'(an8), 32'(an_tab[j % 8]));
      repeat (DIGIT_CYC) @(negedge clk);
    end

    // Shadow writes stay hidden until commit; triple commit merges
    base = ack_cnt[0];
    applyStimulus(0, 1'b1, 3'd2, 6'b000000, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    checkOutput("no_ack_without_commit", 32'(ack_cnt[0] - base), 32'h0);
    waitPhase(32, 9);
    checkOutput("shadow_not_shown", 32'(an8), 32'hFB);
    base = ack_cnt[0];
    applyStimulus(0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    checkOutput("triple_commit_one_ack", 32'(ack_cnt[0] - base), 32'h1);
    waitPhase(32, 9);
    checkOutput("digit2_now_blank", 32'(an8), 32'hFF);

    // Blinking digit 3
    applyStimulus(0, 1'b1, 3'd3, 6'b100110, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    waitPhase(64, 14);
    checkOutput("blink_on_an8", 32'(an8), 32'hF7);
    checkOutput("blink_on_seg8", 32'(seg8), 32'b0000110);
    checkOutput("blink_on_dp8", 32'(dp8), 32'h1);
    waitPhase(64, 46);
    checkOutput("blink_off_an8", 32'(an8), 32'hFF);
    checkOutput("blink_off_seg8", 32'(seg8), 32'h7F);
    waitPhase(64, 50);
    checkOutput("blink_neighbour_an8", 32'(an8), 32'hEF);

    // Five-digit instance, out-of-range write ignored
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 1'b1, 3'(i), {1'b1, 4'(i), 1'b0}, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 3'd6, 6'b111111, 1'b0, 1'b1);
    waitAck(1, 40);
    waitPhase(20, 17);
    checkOutput("n5_last_an5", 32'(an5), 32'h0F);
    checkOutput("n5_last_seg5", 32'(seg5), 32'b1001100);
    waitPhase(20, 1);
    checkOutput("n5_wrap_an5", 32'(an5), 32'h1E);
    checkOutput("n5_wrap_seg5", 32'(seg5), 32'b0000001);

    // Reset while a commit is pending
    applyStimulus(0, 1'b1, 3'd1, 6'b101110, 1'b0, 1'b0);
    waitPhase(32, 4);
    applyStimulus(0, 1'b0, 3'd0, 6'd0, 1'b0, 1'b1);
    checkOutput("pre_reset_an8", 32'(an8), 32'hFD);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_an8", 32'(an8), 32'hFF);
    checkOutput("async_reset_seg8", 32'(seg8), 32'h7F);
    checkOutput("async_reset_dp8", 32'(dp8), 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = ack_cnt[0];
    repeat (40) @(negedge clk);
    checkOutput("no_ack_after_reset", 32'(ack_cnt[0] - base), 32'h0);
    checkOutput("blank_after_reset_an8", 32'(an8), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
